// File: rtl/dmac_burst_scheduler.sv
// Multi-channel DMA command scheduler: per-channel command queues, round-robin burst
// arbitration, AXI-legal burst splitting (length and boundary) and completion tracking.
module dmac_burst_scheduler #(
    parameter int unsigned ADDR_WD         = 32,
    parameter int unsigned DATA_WD         = 32,
    parameter int unsigned CHANNEL_COUNT   = 8,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_BURST_LEN   = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned BOUNDARY        = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [$clog2(CHANNEL_COUNT)-1:0] cmd_chan,
    input  logic [ADDR_WD-1:0]               cmd_src_addr,
    input  logic [ADDR_WD-1:0]               cmd_dst_addr,
    input  logic [ADDR_WD-1:0]               cmd_len,
    input  logic [2:0]                       cmd_size,
    output logic                             brq_valid,
    input  logic                             brq_ready,
    output logic [$clog2(CHANNEL_COUNT)-1:0] brq_chan,
    output logic [ADDR_WD-1:0]               brq_src_addr,
    output logic [ADDR_WD-1:0]               brq_dst_addr,
    output logic [7:0]                       brq_len,
    output logic [2:0]                       brq_size,
    output logic                             brq_last,
    input  logic                             cpl_valid,
    input  logic [$clog2(CHANNEL_COUNT)-1:0] cpl_chan,
    input  logic                             cpl_last,
    output logic                             done_valid,
    output logic [$clog2(CHANNEL_COUNT)-1:0] done_chan,
    output logic [CHANNEL_COUNT-1:0]         chan_busy,
    output logic [1:0]                       err
);

    localparam int unsigned CW      = $clog2(CHANNEL_COUNT);
    localparam int unsigned PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned NW      = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned AW1     = ADDR_WD + 1;
    localparam int unsigned MaxSize = $clog2(DATA_WD / 8);

    localparam logic [1:0] StArb   = 2'd0;
    localparam logic [1:0] StCalc  = 2'd1;
    localparam logic [1:0] StIssue = 2'd2;

    localparam logic [AW1-1:0]     BndW    = AW1'(BOUNDARY);
    localparam logic [ADDR_WD-1:0] BndMask = ADDR_WD'(BOUNDARY - 1);
    localparam logic [AW1-1:0]     MaxLenW = AW1'(MAX_BURST_LEN);

    // Queue storage; the head entry is rewritten in place as bursts are issued
    logic [ADDR_WD-1:0] src_mem  [CHANNEL_COUNT][QUEUE_DEPTH];
    logic [ADDR_WD-1:0] dst_mem  [CHANNEL_COUNT][QUEUE_DEPTH];
    logic [ADDR_WD-1:0] rem_mem  [CHANNEL_COUNT][QUEUE_DEPTH];
    logic [2:0]         size_mem [CHANNEL_COUNT][QUEUE_DEPTH];

    logic [PW-1:0] wr_q  [CHANNEL_COUNT];
    logic [PW-1:0] wr_d  [CHANNEL_COUNT];
    logic [PW-1:0] rd_q  [CHANNEL_COUNT];
    logic [PW-1:0] rd_d  [CHANNEL_COUNT];
    logic [NW-1:0] cnt_q [CHANNEL_COUNT];
    logic [NW-1:0] cnt_d [CHANNEL_COUNT];
    logic [OW-1:0] out_q [CHANNEL_COUNT];
    logic [OW-1:0] out_d [CHANNEL_COUNT];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] gnt_q, gnt_d;

    logic [CW-1:0]      brq_chan_q, brq_chan_d;
    logic [ADDR_WD-1:0] brq_src_q, brq_src_d;
    logic [ADDR_WD-1:0] brq_dst_q, brq_dst_d;
    logic [7:0]         brq_len_q, brq_len_d;
    logic [2:0]         brq_size_q, brq_size_d;
    logic               brq_last_q, brq_last_d;
    logic [8:0]         beats_q, beats_d;

    logic                     done_valid_q;
    logic [CW-1:0]            done_chan_q;
    logic [CHANNEL_COUNT-1:0] busy_q, busy_d;
    logic [1:0]               err_q;

    logic               push, zero_len, hs, pop, cpl_bad, cpl_ok;
    logic [2:0]         cmd_size_c;
    logic               arb_found;
    logic [CW-1:0]      arb_pick;
    logic [ADDR_WD-1:0] h_src, h_dst, h_rem, step;
    logic [2:0]         h_size;
    logic [AW1-1:0]     lim_src, lim_dst, lim;
    logic [8:0]         beats_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cmd_ready  = (cnt_q[cmd_chan] != NW'(QUEUE_DEPTH));
    assign cmd_size_c = (cmd_size > 3'(MaxSize)) ? 3'(MaxSize) : cmd_size;
    assign push       = cmd_valid && cmd_ready && (cmd_len != '0);
    assign zero_len   = cmd_valid && cmd_ready && (cmd_len == '0);
    assign hs         = (state_q == StIssue) && brq_ready;
    assign pop        = hs && brq_last_q;
    assign cpl_bad    = cpl_valid && (out_q[cpl_chan] == '0);
    assign cpl_ok     = cpl_valid && !cpl_bad;

    assign h_src  = src_mem[gnt_q][rd_q[gnt_q]];
    assign h_dst  = dst_mem[gnt_q][rd_q[gnt_q]];
    assign h_rem  = rem_mem[gnt_q][rd_q[gnt_q]];
    assign h_size = size_mem[gnt_q][rd_q[gnt_q]];
    assign step   = ADDR_WD'(beats_q) << brq_size_q;

    // Burst length: the tightest of remaining beats, max burst and both boundary limits
    always_comb begin
        lim_src = (BndW - {1'b0, h_src & BndMask}) >> h_size;
        lim_dst = (BndW - {1'b0, h_dst & BndMask}) >> h_size;
        lim     = {1'b0, h_rem};
        if (MaxLenW < lim) lim = MaxLenW;
        if (lim_src < lim) lim = lim_src;
        if (lim_dst < lim) lim = lim_dst;
        beats_c = lim[8:0];
    end

    // Round-robin search starts one past the last grant
    always_comb begin
        int unsigned idx;
        arb_found = 1'b0;
        arb_pick  = '0;
        idx       = 0;
        for (int i = 1; i <= int'(CHANNEL_COUNT); i++) begin
            idx = (int'(gnt_q) + i) % CHANNEL_COUNT;
            if (!arb_found && (cnt_q[CW'(idx)] != '0) &&
                (out_q[CW'(idx)] < OW'(MAX_OUTSTANDING))) begin
                arb_found = 1'b1;
                arb_pick  = CW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        brq_chan_d = brq_chan_q;
        brq_src_d  = brq_src_q;
        brq_dst_d  = brq_dst_q;
        brq_len_d  = brq_len_q;
        brq_size_d = brq_size_q;
        brq_last_d = brq_last_q;
        beats_d    = beats_q;
        case (state_q)
            StArb: begin
                if (arb_found) begin
                    gnt_d   = arb_pick;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                brq_chan_d = gnt_q;
                brq_src_d  = h_src;
                brq_dst_d  = h_dst;
                brq_len_d  = 8'(beats_c - 9'd1);
                brq_size_d = h_size;
                brq_last_d = (ADDR_WD'(beats_c) == h_rem);
                beats_d    = beats_c;
                state_d    = StIssue;
            end
            StIssue: begin
                if (brq_ready) state_d = StArb;
            end
            default: state_d = StArb;
        endcase
    end

    always_comb begin
        logic push_c, pop_c, inc_c, dec_c;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        out_d = out_q;
        for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
            push_c = push && (cmd_chan == CW'(c));
            pop_c  = pop && (gnt_q == CW'(c));
            inc_c  = hs && (gnt_q == CW'(c));
            dec_c  = cpl_ok && (cpl_chan == CW'(c));
            if (push_c) wr_d[c] = ptr_inc(wr_q[c]);
            if (pop_c) rd_d[c] = ptr_inc(rd_q[c]);
            case ({push_c, pop_c})
                2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                default: cnt_d[c] = cnt_q[c];
            endcase
            case ({inc_c, dec_c})
                2'b10:   out_d[c] = out_q[c] + 1'b1;
                2'b01:   out_d[c] = out_q[c] - 1'b1;
                default: out_d[c] = out_q[c];
            endcase
            busy_d[c] = (cnt_d[c] != '0) || (out_d[c] != '0);
        end
    end

    // Payload storage needs no reset: pointers and counts define validity
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[cmd_chan][wr_q[cmd_chan]]  <= cmd_src_addr;
            dst_mem[cmd_chan][wr_q[cmd_chan]]  <= cmd_dst_addr;
            rem_mem[cmd_chan][wr_q[cmd_chan]]  <= cmd_len >> cmd_size_c;
            size_mem[cmd_chan][wr_q[cmd_chan]] <= cmd_size_c;
        end
        if (hs && !brq_last_q) begin
            src_mem[gnt_q][rd_q[gnt_q]] <= h_src + step;
            dst_mem[gnt_q][rd_q[gnt_q]] <= h_dst + step;
            rem_mem[gnt_q][rd_q[gnt_q]] <= h_rem - ADDR_WD'(beats_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < int'(CHANNEL_COUNT); c++) begin
                wr_q[c]  <= '0;
                rd_q[c]  <= '0;
                cnt_q[c] <= '0;
                out_q[c] <= '0;
            end
            state_q      <= StArb;
            gnt_q        <= '0;
            brq_chan_q   <= '0;
            brq_src_q    <= '0;
            brq_dst_q    <= '0;
            brq_len_q    <= '0;
            brq_size_q   <= '0;
            brq_last_q   <= 1'b0;
            beats_q      <= '0;
            done_valid_q <= 1'b0;
            done_chan_q  <= '0;
            busy_q       <= '0;
            err_q        <= '0;
        end else begin
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            brq_chan_q   <= brq_chan_d;
            brq_src_q    <= brq_src_d;
            brq_dst_q    <= brq_dst_d;
            brq_len_q    <= brq_len_d;
            brq_size_q   <= brq_size_d;
            brq_last_q   <= brq_last_d;
            beats_q      <= beats_d;
            done_valid_q <= cpl_ok && cpl_last;
            if (cpl_ok && cpl_last) done_chan_q <= cpl_chan;
            busy_q       <= busy_d;
            err_q        <= err_q | {cpl_bad, zero_len};
        end
    end

    assign brq_valid    = (state_q == StIssue);
    assign brq_chan     = brq_chan_q;
    assign brq_src_addr = brq_src_q;
    assign brq_dst_addr = brq_dst_q;
    assign brq_len      = brq_len_q;
    assign brq_size     = brq_size_q;
    assign brq_last     = brq_last_q;
    assign done_valid   = done_valid_q;
    assign done_chan    = done_chan_q;
    assign chan_busy    = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_dmac_burst_scheduler.sv
// Directed self-checking bench for dmac_burst_scheduler with default parameters.
module tb_dmac_burst_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_chan;
    logic [31:0] cmd_src_addr;
    logic [31:0] cmd_dst_addr;
    logic [31:0] cmd_len;
    logic [2:0]  cmd_size;
    logic        brq_valid;
    logic        brq_ready;
    logic [2:0]  brq_chan;
    logic [31:0] brq_src_addr;
    logic [31:0] brq_dst_addr;
    logic [7:0]  brq_len;
    logic [2:0]  brq_size;
    logic        brq_last;
    logic        cpl_valid;
    logic [2:0]  cpl_chan;
    logic        cpl_last;
    logic        done_valid;
    logic [2:0]  done_chan;
    logic [7:0]  chan_busy;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmac_burst_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_chan     (cmd_chan),
        .cmd_src_addr (cmd_src_addr),
        .cmd_dst_addr (cmd_dst_addr),
        .cmd_len      (cmd_len),
        .cmd_size     (cmd_size),
        .brq_valid    (brq_valid),
        .brq_ready    (brq_ready),
        .brq_chan     (brq_chan),
        .brq_src_addr (brq_src_addr),
        .brq_dst_addr (brq_dst_addr),
        .brq_len      (brq_len),
        .brq_size     (brq_size),
        .brq_last     (brq_last),
        .cpl_valid    (cpl_valid),
        .cpl_chan     (cpl_chan),
        .cpl_last     (cpl_last),
        .done_valid   (done_valid),
        .done_chan    (done_chan),
        .chan_busy    (chan_busy),
        .err          (err)
    );

    task automatic do_reset();
        rst       = 1'b1;
        brq_ready = 1'b0;
        cmd_valid = 1'b0;
        cpl_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] ch, input logic [31:0] src, input logic [31:0] dst,
                        input logic [31:0] len, input logic [2:0] size);
        cmd_valid    = 1'b1;
        cmd_chan     = ch;
        cmd_src_addr = src;
        cmd_dst_addr = dst;
        cmd_len      = len;
        cmd_size     = size;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic cpl(input logic [2:0] ch, input logic last);
        cpl_valid = 1'b1;
        cpl_chan  = ch;
        cpl_last  = last;
        @(posedge clk);
        #1 cpl_valid = 1'b0;
    endtask

    task automatic wait_brq(input int max_cycles, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (brq_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_hs();
        brq_ready = 1'b1;
        @(posedge clk);
        #1 brq_ready = 1'b0;
    endtask

    task automatic test_reset();
        cmd_chan = 3'd0;
        do_reset();
        checks++; if (brq_valid !== 1'b0) begin errors++;
            $display("FAIL rst_brq_valid got %b exp 0", brq_valid); end
        checks++; if (done_valid !== 1'b0) begin errors++;
            $display("FAIL rst_done_valid got %b exp 0", done_valid); end
        checks++; if (chan_busy !== 8'h00) begin errors++;
            $display("FAIL rst_chan_busy got %h exp 00", chan_busy); end
        checks++; if (err !== 2'b00) begin errors++;
            $display("FAIL rst_err got %b exp 00", err); end
        checks++; if (cmd_ready !== 1'b1) begin errors++;
            $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if ({brq_chan, brq_len, brq_last} !== 12'h000) begin errors++;
            $display("FAIL rst_brq_fields got %h exp 000", {brq_chan, brq_len, brq_last}); end
    endtask

    task automatic test_single();
        bit got;
        do_reset();
        send(3'd0, 32'h1000, 32'h2000, 32'd64, 3'd2);
        wait_brq(10, got);
        checks++; if (got !== 1'b1) begin errors++;
            $display("FAIL single_timeout got %b exp 1", got); end
        checks++; if ({brq_chan, brq_src_addr, brq_dst_addr} !== {3'd0, 32'h1000, 32'h2000})
            begin errors++; $display("FAIL single_addr got %0d %h %h exp 0 1000 2000",
                brq_chan, brq_src_addr, brq_dst_addr); end
        checks++; if ({brq_len, brq_size, brq_last} !== {8'd15, 3'd2, 1'b1}) begin errors++;
            $display("FAIL single_len got %0d %0d %b exp 15 2 1", brq_len, brq_size, brq_last);
        end
        do_hs();
        @(negedge clk);
        checks++; if ({brq_valid, chan_busy} !== {1'b0, 8'h01}) begin errors++;
            $display("FAIL single_after_hs got %b %h exp 0 01", brq_valid, chan_busy); end
        cpl(3'd0, 1'b1);
        checks++; if ({done_valid, done_chan} !== {1'b1, 3'd0}) begin errors++;
            $display("FAIL single_done got %b %0d exp 1 0", done_valid, done_chan); end
        checks++; if (chan_busy !== 8'h00) begin errors++;
            $display("FAIL single_busy_clear got %h exp 00", chan_busy); end
        @(posedge clk); #1;
        checks++; if (done_valid !== 1'b0) begin errors++;
            $display("FAIL single_done_pulse got %b exp 0", done_valid); end
    endtask

    task automatic test_boundary();
        bit got;
        do_reset();
        send(3'd1, 32'h0FF8, 32'h3000, 32'd64, 3'd2);
        wait_brq(10, got);
        checks++; if ({got, brq_chan, brq_src_addr, brq_dst_addr} !==
                      {1'b1, 3'd1, 32'h0FF8, 32'h3000}) begin errors++;
            $display("FAIL bnd_first_addr got %b %0d %h %h exp 1 1 ff8 3000",
                got, brq_chan, brq_src_addr, brq_dst_addr); end
        checks++; if ({brq_len, brq_last} !== {8'd1, 1'b0}) begin errors++;
            $display("FAIL bnd_first_len got %0d %b exp 1 0", brq_len, brq_last); end
        do_hs();
        wait_brq(10, got);
        checks++; if ({got, brq_src_addr, brq_dst_addr} !== {1'b1, 32'h1000, 32'h3008})
            begin errors++; $display("FAIL bnd_second_addr got %b %h %h exp 1 1000 3008",
                got, brq_src_addr, brq_dst_addr); end
        checks++; if ({brq_len, brq_last} !== {8'd13, 1'b1}) begin errors++;
            $display("FAIL bnd_second_len got %0d %b exp 13 1", brq_len, brq_last); end
        do_hs();
        @(negedge clk);
        checks++; if (chan_busy !== 8'h02) begin errors++;
            $display("FAIL bnd_busy got %h exp 02", chan_busy); end
        cpl(3'd1, 1'b0);
        checks++; if (done_valid !== 1'b0) begin errors++;
            $display("FAIL bnd_early_done got %b exp 0", done_valid); end
        cpl(3'd1, 1'b1);
        checks++; if ({done_valid, done_chan, chan_busy} !== {1'b1, 3'd1, 8'h00}) begin
            errors++; $display("FAIL bnd_done got %b %0d %h exp 1 1 00",
                done_valid, done_chan, chan_busy); end
    endtask

    task automatic test_interleave();
        bit          got;
        int          n;
        logic [2:0]  seq_ch  [16];
        logic [31:0] seq_src [16];
        logic [2:0]  exp_ch  [8];
        logic [31:0] exp_src [8];
        exp_ch  = '{3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5, 3'd2, 3'd5};
        exp_src = '{32'h0000, 32'h4000, 32'h0040, 32'h4040,
                    32'h0080, 32'h4080, 32'h00C0, 32'h40C0};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send(3'd2, 32'(k * 128), 32'h8000 + 32'(k * 128), 32'd128, 3'd2);
            send(3'd5, 32'h4000 + 32'(k * 128), 32'hC000 + 32'(k * 128), 32'd128, 3'd2);
        end
        n = 0;
        brq_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (brq_valid && n < 16) begin
                seq_ch[n]  = brq_chan;
                seq_src[n] = brq_src_addr;
                n++;
            end
        end
        checks++; if (n !== 8) begin errors++;
            $display("FAIL rr_burst_count got %0d exp 8", n); end
        for (int i = 0; i < 8; i++) begin
            checks++; if ({seq_ch[i], seq_src[i]} !== {exp_ch[i], exp_src[i]}) begin errors++;
                $display("FAIL rr_seq[%0d] got %0d %h exp %0d %h",
                    i, seq_ch[i], seq_src[i], exp_ch[i], exp_src[i]); end
        end
        checks++; if ({brq_valid, chan_busy} !== {1'b0, 8'h24}) begin errors++;
            $display("FAIL rr_stall got %b %h exp 0 24", brq_valid, chan_busy); end
        cpl(3'd2, 1'b0);
        wait_brq(10, got);
        checks++; if ({got, brq_chan, brq_src_addr} !== {1'b1, 3'd2, 32'h0100}) begin errors++;
            $display("FAIL rr_after_cpl got %b %0d %h exp 1 2 100",
                got, brq_chan, brq_src_addr); end
        brq_ready = 1'b0;
    endtask

    task automatic test_queue_full();
        do_reset();
        for (int k = 0; k < 3; k++) send(3'd3, 32'(k * 64), 32'h1000, 32'd64, 3'd2);
        cmd_chan = 3'd3; #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++;
            $display("FAIL full_three got %b exp 1", cmd_ready); end
        send(3'd3, 32'h0C0, 32'h1000, 32'd64, 3'd2);
        cmd_chan = 3'd3; #1;
        checks++; if (cmd_ready !== 1'b0) begin errors++;
            $display("FAIL full_ch3 got %b exp 0", cmd_ready); end
        cmd_chan = 3'd4; #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++;
            $display("FAIL full_ch4 got %b exp 1", cmd_ready); end
        @(negedge clk);
        checks++; if (chan_busy !== 8'h08) begin errors++;
            $display("FAIL full_busy got %h exp 08", chan_busy); end
    endtask

    task automatic test_errors();
        bit got;
        do_reset();
        send(3'd0, 32'h0, 32'h0, 32'd0, 3'd2);
        checks++; if (err !== 2'b01) begin errors++;
            $display("FAIL err_zero_len got %b exp 01", err); end
        wait_brq(8, got);
        checks++; if ({got, chan_busy} !== {1'b0, 8'h00}) begin errors++;
            $display("FAIL err_no_burst got %b %h exp 0 00", got, chan_busy); end
        cpl(3'd6, 1'b1);
        checks++; if ({err, done_valid, chan_busy} !== {2'b11, 1'b0, 8'h00}) begin errors++;
            $display("FAIL err_idle_cpl got %b %b %h exp 11 0 00", err, done_valid, chan_busy);
        end
        send(3'd6, 32'h10, 32'h20, 32'd4, 3'd2);
        wait_brq(10, got);
        checks++; if ({got, brq_chan, brq_len, brq_last} !== {1'b1, 3'd6, 8'd0, 1'b1}) begin
            errors++; $display("FAIL err_ch6_burst got %b %0d %0d %b exp 1 6 0 1",
                got, brq_chan, brq_len, brq_last); end
        do_hs();
        cpl(3'd6, 1'b1);
        checks++; if ({done_valid, done_chan, err} !== {1'b1, 3'd6, 2'b11}) begin errors++;
            $display("FAIL err_ch6_done got %b %0d %b exp 1 6 11", done_valid, done_chan, err);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        send(3'd0, 32'h0, 32'h100, 32'd64, 3'd2);
        send(3'd1, 32'h200, 32'h300, 32'd64, 3'd2);
        wait_brq(10, got);
        checks++; if (got !== 1'b1) begin errors++;
            $display("FAIL mid_pre_valid got %b exp 1", got); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        cmd_chan = 3'd0; #1;
        checks++; if ({brq_valid, chan_busy, done_valid, err, cmd_ready} !==
                      {1'b0, 8'h00, 1'b0, 2'b00, 1'b1}) begin errors++;
            $display("FAIL mid_reset got %b %h %b %b %b exp 0 00 0 00 1",
                brq_valid, chan_busy, done_valid, err, cmd_ready); end
        wait_brq(10, got);
        checks++; if ({got, chan_busy} !== {1'b0, 8'h00}) begin errors++;
            $display("FAIL mid_queues_empty got %b %h exp 0 00", got, chan_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_interleave();
        test_queue_full();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
